// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller:
// FSM states, redirect sources (ordered by priority) and PC helpers.
package fetch_ctrl_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] DEFAULT_EXC_VECTOR = 32'h0000_0180;
    localparam logic [PC_WIDTH-1:0] PC_STEP            = 32'h0000_0004;
    localparam logic [15:0]         REDIRECT_CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

    // Numeric order is the redirect priority: a larger value wins.
    typedef enum logic [2:0] {
        RS_NONE   = 3'd0,
        RS_BRANCH = 3'd1,
        RS_JUMP   = 3'd2,
        RS_ERET   = 3'd3,
        RS_EXC    = 3'd4
    } redirect_src_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == REDIRECT_CNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_sel.sv
// Combinational priority selector over the redirect requests seen this cycle:
// exception > exception return > jump > taken branch.
module redirect_sel
    import fetch_ctrl_pkg::*;
(
    input  logic                exc_valid,
    input  logic [PC_WIDTH-1:0] exc_target,
    input  logic                eret_valid,
    input  logic [PC_WIDTH-1:0] epc,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                sel_valid,
    output logic [PC_WIDTH-1:0] sel_target,
    output redirect_src_e       sel_src
);

    // Highest-priority active request wins.
    always_comb begin
        sel_valid  = 1'b0;
        sel_target = '0;
        sel_src    = RS_NONE;
        if (exc_valid) begin
            sel_valid  = 1'b1;
            sel_target = exc_target;
            sel_src    = RS_EXC;
        end else if (eret_valid) begin
            sel_valid  = 1'b1;
            sel_target = epc;
            sel_src    = RS_ERET;
        end else if (jump_valid) begin
            sel_valid  = 1'b1;
            sel_target = jump_target;
            sel_src    = RS_JUMP;
        end else if (branch_taken) begin
            sel_valid  = 1'b1;
            sel_target = branch_target;
            sel_src    = RS_BRANCH;
        end else begin
            sel_valid  = 1'b0;
            sel_target = '0;
            sel_src    = RS_NONE;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences the PC, stalls on instruction memory or decode
// hazards, and applies or parks control-flow redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pc_cur,
    input  logic                hazard_stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                exc_valid,
    input  logic                eret_valid,
    input  logic [PC_WIDTH-1:0] epc,
    input  logic                imem_ready,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                pc_stall,
    output logic                imem_req,
    output logic                if_valid,
    output logic [15:0]         redirect_cnt
);

    fetch_state_e        state_r, state_s;
    logic                pend_valid_r, pend_valid_s;
    logic [PC_WIDTH-1:0] pend_target_r, pend_target_s;
    redirect_src_e       pend_src_r, pend_src_s;
    logic [15:0]         cnt_r, cnt_s;

    logic                new_valid_s;
    logic [PC_WIDTH-1:0] new_target_s;
    redirect_src_e       new_src_s;

    logic                merged_valid_s;
    logic [PC_WIDTH-1:0] merged_target_s;
    redirect_src_e       merged_src_s;

    redirect_sel u_redirect_sel (
        .exc_valid     (exc_valid),
        .exc_target    (EXC_VECTOR),
        .eret_valid    (eret_valid),
        .epc           (epc),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .sel_valid     (new_valid_s),
        .sel_target    (new_target_s),
        .sel_src       (new_src_s)
    );

    // Combine this cycle's request with the parked one; equal priority takes the newer.
    always_comb begin
        merged_valid_s  = pend_valid_r;
        merged_target_s = pend_target_r;
        merged_src_s    = pend_src_r;
        if (new_valid_s && (!pend_valid_r || (new_src_s >= pend_src_r))) begin
            merged_valid_s  = 1'b1;
            merged_target_s = new_target_s;
            merged_src_s    = new_src_s;
        end else begin
            merged_valid_s  = pend_valid_r;
            merged_target_s = pend_target_r;
            merged_src_s    = pend_src_r;
        end
    end

    // Next-state, pending-register update and output decode.
    always_comb begin
        state_s       = state_r;
        pend_valid_s  = pend_valid_r;
        pend_target_s = pend_target_r;
        pend_src_s    = pend_src_r;
        cnt_s         = cnt_r;
        pc_next       = pc_cur + PC_STEP;
        pc_stall      = 1'b1;
        imem_req      = 1'b0;
        if_valid      = 1'b0;
        case (state_r)
            ST_BOOT: begin
                pc_next       = RESET_PC;
                state_s       = ST_FETCH;
                pend_valid_s  = merged_valid_s;
                pend_target_s = merged_target_s;
                pend_src_s    = merged_src_s;
            end
            ST_FETCH, ST_WAIT: begin
                imem_req = 1'b1;
                if (merged_valid_s) begin
                    pc_next = merged_target_s;
                end else begin
                    pc_next = pc_cur + PC_STEP;
                end
                if (!imem_ready) begin
                    pc_stall      = 1'b1;
                    if_valid      = 1'b0;
                    state_s       = ST_WAIT;
                    pend_valid_s  = merged_valid_s;
                    pend_target_s = merged_target_s;
                    pend_src_s    = merged_src_s;
                end else if (!hazard_stall || exc_valid) begin
                    // PC advances: any redirect is applied now and squashes the word.
                    pc_stall     = 1'b0;
                    if_valid     = !merged_valid_s;
                    state_s      = ST_FETCH;
                    pend_valid_s = 1'b0;
                    pend_src_s   = RS_NONE;
                    if (merged_valid_s) begin
                        cnt_s = sat_inc16(cnt_r);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    pc_stall      = 1'b1;
                    if_valid      = 1'b1;
                    state_s       = state_r;
                    pend_valid_s  = merged_valid_s;
                    pend_target_s = merged_target_s;
                    pend_src_s    = merged_src_s;
                end
            end
            default: begin
                pc_next      = RESET_PC;
                state_s      = ST_BOOT;
                pend_valid_s = 1'b0;
                pend_src_s   = RS_NONE;
            end
        endcase
    end

    // State, pending redirect and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_BOOT;
            pend_valid_r  <= 1'b0;
            pend_target_r <= '0;
            pend_src_r    <= RS_NONE;
            cnt_r         <= 16'd0;
        end else begin
            state_r       <= state_s;
            pend_valid_r  <= pend_valid_s;
            pend_target_r <= pend_target_s;
            pend_src_r    <= pend_src_s;
            cnt_r         <= cnt_s;
        end
    end

    assign redirect_cnt = cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot sequence, a vector table walked one
// cycle per row, and an asynchronous reset taken while waiting on memory.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic        hazard_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic        imem_ready;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        imem_req;
    logic        if_valid;
    logic [15:0] redirect_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0180)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .hazard_stall  (hazard_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .exc_valid     (exc_valid),
        .eret_valid    (eret_valid),
        .epc           (epc),
        .imem_ready    (imem_ready),
        .pc_next       (pc_next),
        .pc_stall      (pc_stall),
        .imem_req      (imem_req),
        .if_valid      (if_valid),
        .redirect_cnt  (redirect_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        rdy;
        logic        hz;
        logic        br;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic        ex;
        logic        er;
        logic [31:0] epc;
        logic [31:0] e_next;
        logic        e_stall;
        logic        e_ifv;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_cur        = v.pc;
        imem_ready    = v.rdy;
        hazard_stall  = v.hz;
        branch_taken  = v.br;
        branch_target = v.bt;
        jump_valid    = v.jv;
        jump_target   = v.jt;
        exc_valid     = v.ex;
        eret_valid    = v.er;
        epc           = v.epc;
    endtask

    task automatic clear_inputs();
        hazard_stall  = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump_valid    = 1'b0;
        jump_target   = 32'h0;
        exc_valid     = 1'b0;
        eret_valid    = 1'b0;
        epc           = 32'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pc_next"},  pc_next,              32'h0);
        chk({tag, " pc_stall"}, {31'd0, pc_stall},    32'd1);
        chk({tag, " imem_req"}, {31'd0, imem_req},    32'd0);
        chk({tag, " if_valid"}, {31'd0, if_valid},    32'd0);
        chk({tag, " cnt"},      {16'd0, redirect_cnt}, 32'd0);
    endtask

    initial begin
        logic [31:0] nxt;

        //          pc            rdy   hz    br    bt           jv    jt           ex    er    epc          e_next       stall ifv   cnt
        tbl[0]  = '{32'h10,       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h14,      1'b1, 1'b0, 16'd0};
        tbl[1]  = '{32'h10,       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h14,      1'b1, 1'b0, 16'd0};
        tbl[2]  = '{32'h10,       1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h14,      1'b1, 1'b0, 16'd0};
        tbl[3]  = '{32'h10,       1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h14,      1'b0, 1'b1, 16'd0};
        tbl[4]  = '{32'h14,       1'b0, 1'b0, 1'b1, 32'h100,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h100,     1'b1, 1'b0, 16'd0};
        tbl[5]  = '{32'h14,       1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h100,     1'b0, 1'b0, 16'd0};
        tbl[6]  = '{32'h100,      1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h200,     1'b1, 1'b0, 32'h0,       32'h180,     1'b0, 1'b0, 16'd1};
        tbl[7]  = '{32'h180,      1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h184,     1'b1, 1'b1, 16'd2};
        tbl[8]  = '{32'h180,      1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h44,      32'h44,      1'b1, 1'b1, 16'd2};
        tbl[9]  = '{32'h180,      1'b1, 1'b1, 1'b1, 32'h300,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h44,      1'b1, 1'b1, 16'd2};
        tbl[10] = '{32'h180,      1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h44,      1'b0, 1'b0, 16'd2};
        tbl[11] = '{32'h44,       1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       32'h180,     1'b0, 1'b0, 16'd3};
        tbl[12] = '{32'h180,      1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h200,     1'b0, 1'b0, 32'h0,       32'h200,     1'b1, 1'b0, 16'd4};
        tbl[13] = '{32'h180,      1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       32'h180,     1'b1, 1'b0, 16'd4};
        tbl[14] = '{32'h180,      1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h180,     1'b0, 1'b0, 16'd4};
        tbl[15] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,       1'b0, 1'b1, 16'd5};
        tbl[16] = '{32'h8,        1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h200,     1'b0, 1'b0, 32'h0,       32'h200,     1'b0, 1'b0, 16'd5};
        tbl[17] = '{32'h200,      1'b1, 1'b0, 1'b1, 32'h20,      1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h20,      1'b0, 1'b0, 16'd6};
        tbl[18] = '{32'h20,       1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h24,      1'b0, 1'b1, 16'd7};

        reset      = 1'b1;
        pc_cur     = 32'h0;
        imem_ready = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("boot");

        // Boot with memory always ready and the PC register following pc_next.
        nxt = pc_stall ? pc_cur : pc_next;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            pc_cur = nxt;
            @(negedge clk);
            chk($sformatf("seq%0d fetch addr", k), pc_cur, 32'(k * 4));
            chk($sformatf("seq%0d pc_next", k), pc_next, 32'(k * 4 + 4));
            chk($sformatf("seq%0d if_valid", k), {31'd0, if_valid}, 32'd1);
            chk($sformatf("seq%0d imem_req", k), {31'd0, imem_req}, 32'd1);
            nxt = pc_stall ? pc_cur : pc_next;
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d pc_next", i), pc_next, tbl[i].e_next);
            chk($sformatf("row%0d pc_stall", i), {31'd0, pc_stall}, {31'd0, tbl[i].e_stall});
            chk($sformatf("row%0d imem_req", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("row%0d if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_ifv});
            chk($sformatf("row%0d cnt", i), {16'd0, redirect_cnt}, {16'd0, tbl[i].e_cnt});
            @(posedge clk);
            #1;
        end
        clear_inputs();
        chk("final cnt", {16'd0, redirect_cnt}, 32'd7);

        // Park a branch while waiting, then reset asynchronously mid-cycle.
        pc_cur        = 32'h30;
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        @(posedge clk);
        #1;
        chk("wait pend pc_next", pc_next, 32'h100);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async rst");
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("post rst boot");
        @(posedge clk);
        #1;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("post rst pc_next", pc_next, 32'h34);
        chk("post rst if_valid", {31'd0, if_valid}, 32'd1);
        chk("post rst pc_stall", {31'd0, pc_stall}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, 32'h0000_0180, exception entry address.
REQ-003 clk  in  1  system clock; all fetch_ctrl state updates on posedge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 pc_cur  in  32  current value of the PC register.
REQ-006 hazard_stall  in  1  decode hazard; freeze fetch.
REQ-007 branch_taken / branch_target  in  1 / 32  resolved taken branch and its target.
REQ-008 jump_valid / jump_target  in  1 / 32  jump request and its target.
REQ-009 exc_valid  in  1  exception; redirect to EXC_VECTOR.
REQ-010 eret_valid / epc  in  1 / 32  exception return and its return address.
REQ-011 imem_ready  in  1  instruction memory has returned the word for the address currently requested.
REQ-012 pc_next  out  32  value presented to the PC register input.
REQ-013 pc_stall  out  1  holds the PC register.
REQ-014 imem_req  out  1  fetch request for pc_cur.
REQ-015 if_valid  out  1  fetched word is valid for decode; 0 inserts a bubble.
REQ-016 redirect_cnt  out  16  saturating count of applied redirects.

Function
REQ-017 States: BOOT, FETCH, WAIT. Reset enters BOOT; BOOT lasts one cycle and then moves to FETCH.
REQ-018 BOOT: imem_req=0, pc_stall=1, if_valid=0, pc_next=RESET_PC.
REQ-019 FETCH/WAIT: imem_req=1. If imem_ready=0, assert pc_stall=1 and if_valid=0, and go to or stay in WAIT.
REQ-020 FETCH/WAIT with imem_ready=1 and hazard_stall=0: pc_stall=0, if_valid=1 unless squashed, go to FETCH.
REQ-021 FETCH/WAIT with imem_ready=1 and hazard_stall=1: pc_stall=1, if_valid=1, stay in the current state; the word is re-presented next cycle.
REQ-022 Redirect priority: exc_valid > eret_valid > jump_valid > branch_taken. Targets are EXC_VECTOR, epc, jump_target and branch_target respectively.
REQ-023 With no redirect active or pending, pc_next = pc_cur + 4, 32-bit wrap; 32'hFFFF_FFFC advances to 32'h0.
REQ-024 A redirect seen in the same cycle as imem_ready=1 and hazard_stall=0 is applied immediately: pc_next = target, if_valid=0 (the sequential word is squashed).
REQ-025 A redirect seen in any other cycle is latched into a pending register (valid bit + 32-bit target). A higher-priority redirect overwrites a latched one; a lower-priority one is ignored.
REQ-026 While the pending register is valid, pc_next = pending target. The pending entry is cleared on the first cycle with imem_ready=1 and hazard_stall=0; that cycle has if_valid=0.
REQ-027 exc_valid overrides hazard_stall: pc_stall=0 and pc_next=EXC_VECTOR even when hazard_stall=1, provided imem_ready=1.
REQ-028 redirect_cnt increments by 1 per applied redirect and saturates at 16'hFFFF.
REQ-029 Outputs are combinational from state, pending register and inputs; there is no added latency between imem_ready and pc_stall deassertion.

Reset
REQ-030 Reset is asynchronous and active-high. It forces state=BOOT, clears the pending register, sets redirect_cnt=0, and drives imem_req=0, pc_stall=1, if_valid=0 and pc_next=RESET_PC.
REQ-031 Reset asserted mid-WAIT discards any outstanding fetch and pending redirect; the PC register's own reset loads 0.

Structure
REQ-032 The state encoding, the redirect-source enum, PC_WIDTH and the default EXC_VECTOR belong in a shared package.
REQ-033 The only sub-module is redirect_sel: a combinational priority selector returning valid and target.

Verification
REQ-034 Reset, then imem_ready=1 constantly, with pc_cur following pc_next -> BOOT for one cycle; fetches 0x0, 0x4, 0x8; if_valid=1 from the second cycle.
REQ-035 imem_ready=0 for 3 cycles at pc_cur=0x10 -> pc_stall=1 and if_valid=0 for 3 cycles; pc_next=0x14 when ready rises.
REQ-036 branch_taken to 0x100 during WAIT, then ready -> pending set; pc_next=0x100, if_valid=0; redirect_cnt=1.
REQ-037 jump_valid to 0x200 and exc_valid together while ready=1 -> pc_next=0x180, if_valid=0; the jump is dropped.
REQ-038 hazard_stall=1 with ready=1, then eret_valid with epc=0x44 -> stall holds the PC; pending applied when the stall drops; pc_next=0x44.
REQ-039 pc_cur=32'hFFFF_FFFC with ready=1 -> pc_next=0x0. Reset asserted mid-WAIT -> outputs take reset values in the same cycle.
